// File: rtl/dma_channel_arbiter_if.sv
// Bus bundle between the DMA channel arbiter, the DREQ/DACK pins, the CPU hold
// handshake and the register/datapath block.
interface dma_channel_arbiter_if;
  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;

  // Requests and register configuration
  logic [NCH-1:0] DREQ;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] sw_req;
  logic [NCH-1:0] mode_block;
  logic           cmd_disable;
  logic           cmd_rot_prio;
  logic           cmd_dreq_low;
  logic           cmd_dack_high;
  logic           cmd_compressed;

  // Datapath status and external handshake
  logic           addr_lo_wrap;
  logic           tc_in;
  logic           EOP_N;
  logic           HLDA;

  // Arbiter results and strobes
  logic           HRQ;
  logic [NCH-1:0] DACK;
  logic           grant_vld;
  logic [CHW-1:0] grant_ch;
  logic           ld_addr;
  logic           xfer_stb;
  logic [NCH-1:0] tc_done;
  logic [NCH-1:0] req_pending;

  modport slave (
    input  DREQ, mask, sw_req, mode_block,
    input  cmd_disable, cmd_rot_prio, cmd_dreq_low, cmd_dack_high, cmd_compressed,
    input  addr_lo_wrap, tc_in, EOP_N, HLDA,
    output HRQ, DACK, grant_vld, grant_ch, ld_addr, xfer_stb, tc_done, req_pending
  );

  modport master (
    output DREQ, mask, sw_req, mode_block,
    output cmd_disable, cmd_rot_prio, cmd_dreq_low, cmd_dack_high, cmd_compressed,
    output addr_lo_wrap, tc_in, EOP_N, HLDA,
    input  HRQ, DACK, grant_vld, grant_ch, ld_addr, xfer_stb, tc_done, req_pending
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// Priority arbiter and S0/S1/S2/S4 transfer-timing sequencer for the 4-channel
// 8237A-style DMA block. Arbitration happens only in SI; the winner owns the bus
// until SREL.
// Optional feature macro: DMA_COMPRESSED_TIMING_EN (2-cycle block transfers when
// cmd_compressed = 1; S1 is revisited only when the low address byte wraps).
module dma_channel_arbiter (
  input logic                  CLK,
  input logic                  RESET,
  dma_channel_arbiter_if.slave bus
);
  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;

  typedef enum logic [2:0] {SI, S0, S1, S2, S4, SREL} state_t;

  state_t         state;
  logic [CHW-1:0] prio_ptr;
  logic           end_flag;

  logic [NCH-1:0] valid;
  logic [CHW-1:0] winner;
  logic [NCH-1:0] grant_oh;
  logic [NCH-1:0] dack_idle;
  logic [NCH-1:0] dack_on;
  logic           ended;
  logic           skip_s1;

  // First valid channel searching upward from start, wrapping 3 -> 0
  function automatic logic [CHW-1:0] pick(input logic [NCH-1:0] v,
                                          input logic [CHW-1:0] start);
    logic [CHW-1:0] idx;
    pick = start;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      idx = start + CHW'(k);
      if (v[idx]) pick = idx;
    end
  endfunction

  // Request qualification: polarity, mask, software request, global disable
  always_comb begin
    valid = ((bus.DREQ ^ {NCH{bus.cmd_dreq_low}}) & ~bus.mask) | bus.sw_req;
    if (bus.cmd_disable) valid = '0;
  end

  assign winner    = pick(valid, bus.cmd_rot_prio ? prio_ptr : CHW'(0));
  assign grant_oh  = NCH'(1) << bus.grant_ch;
  assign dack_idle = {NCH{~bus.cmd_dack_high}};
  assign dack_on   = bus.cmd_dack_high ? grant_oh : ~grant_oh;
  assign ended     = bus.tc_in | ~bus.EOP_N | end_flag;

`ifdef DMA_COMPRESSED_TIMING_EN
  assign skip_s1 = bus.cmd_compressed & ~bus.addr_lo_wrap;
`else
  logic unused_compressed;
  assign unused_compressed = ^{bus.cmd_compressed, bus.addr_lo_wrap};
  assign skip_s1 = 1'b0;
`endif

  // Sequencer; every output is registered and reflects the state being entered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= SI;
      prio_ptr        <= '0;
      end_flag        <= 1'b0;
      bus.HRQ         <= 1'b0;
      bus.DACK        <= dack_idle;
      bus.grant_vld   <= 1'b0;
      bus.grant_ch    <= '0;
      bus.ld_addr     <= 1'b0;
      bus.xfer_stb    <= 1'b0;
      bus.tc_done     <= '0;
      bus.req_pending <= '0;
    end else begin
      bus.ld_addr     <= 1'b0;
      bus.xfer_stb    <= 1'b0;
      bus.tc_done     <= '0;
      bus.DACK        <= dack_idle;
      bus.req_pending <= valid;
      unique case (state)
        SI: begin
          if (|valid) begin
            bus.grant_ch  <= winner;
            bus.grant_vld <= 1'b1;
            bus.HRQ       <= 1'b1;
            state         <= S0;
          end
        end
        S0: begin
          if (bus.HLDA) begin
            bus.ld_addr <= 1'b1;
            bus.DACK    <= dack_on;
            state       <= S1;
          end
        end
        S1: begin
          if (!bus.HLDA) begin
            bus.HRQ       <= 1'b0;
            bus.grant_vld <= 1'b0;
            state         <= SREL;
          end else begin
            bus.DACK <= dack_on;
            state    <= S2;
          end
        end
        S2: begin
          if (!bus.EOP_N) end_flag <= 1'b1;
          if (!bus.HLDA) begin
            bus.HRQ       <= 1'b0;
            bus.grant_vld <= 1'b0;
            state         <= SREL;
          end else begin
            bus.xfer_stb <= 1'b1;
            bus.DACK     <= dack_on;
            state        <= S4;
          end
        end
        S4: begin
          if (!bus.HLDA || ended || !bus.mode_block[bus.grant_ch]) begin
            if (bus.HLDA && ended) bus.tc_done <= grant_oh;
            bus.HRQ       <= 1'b0;
            bus.grant_vld <= 1'b0;
            state         <= SREL;
          end else if (skip_s1) begin
            bus.DACK <= dack_on;
            state    <= S2;
          end else begin
            bus.ld_addr <= 1'b1;
            bus.DACK    <= dack_on;
            state       <= S1;
          end
        end
        SREL: begin
          prio_ptr <= bus.grant_ch + CHW'(1);
          end_flag <= 1'b0;
          state    <= SI;
        end
        default: state <= SI;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: a cycle-accurate vector table
// for the single-mode handshake and request qualification, then directed
// multi-cycle sequences for priority rotation, block mode, EOP, HLDA abort,
// compressed timing and reset.
module tb_dma_channel_arbiter;
  logic CLK;
  logic RESET;

  dma_channel_arbiter_if bus ();

  dma_channel_arbiter dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Results of the last run_xfer
  int         n_stb;
  int         n_tcd;
  int         tcd_rel;
  int         done_cyc;
  logic [3:0] tcd_seen;
  logic [1:0] g_ch;
  int         gap_a[8];

  typedef struct packed {
    logic [3:0] dreq;
    logic [3:0] mask;
    logic [3:0] sw;
    logic       low;
    logic       dis;
    logic       hlda;
    logic       hrq;
    logic       gv;
    logic [1:0] gch;
    logic       ld;
    logic       xs;
    logic [3:0] dack;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl[18];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Grant, then HLDA one cycle after HRQ; reacts per cycle to shape tc/EOP/wrap/drop
  task automatic run_xfer(input int tc_at, input int eop_at, input int drop_at,
                          input int wrap_at, input bit both, input bit withdraw);
    int   last;
    int   cyc;
    logic prev_ld;
    n_stb = 0; n_tcd = 0; tcd_rel = 0; tcd_seen = '0; last = 0; prev_ld = 1'b0;
    for (int i = 0; i < 8; i++) gap_a[i] = 0;
    for (int i = 0; i < 20 && !bus.HRQ; i++) tick();
    chk("hrq_rise", bus.HRQ, 1);
    g_ch = bus.grant_ch;
    if (withdraw) begin
      bus.DREQ = '0; bus.mask = '1; bus.cmd_disable = 1'b1;
    end
    tick();
    bus.HLDA = 1'b1;
    for (cyc = 1; cyc <= 80; cyc++) begin
      tick();
      bus.tc_in = 1'b0; bus.EOP_N = 1'b1; bus.addr_lo_wrap = 1'b0;
      if (bus.xfer_stb) begin
        n_stb++;
        if (n_stb <= 8) gap_a[n_stb-1] = cyc - last;
        last = cyc;
        if (n_stb == tc_at) begin
          bus.tc_in = 1'b1;
          if (both) bus.EOP_N = 1'b0;
        end
        if (n_stb == wrap_at) bus.addr_lo_wrap = 1'b1;
      end
      if (prev_ld && n_stb + 1 == eop_at) bus.EOP_N = 1'b0;
      if (prev_ld && n_stb + 1 == drop_at) bus.HLDA = 1'b0;
      if (|bus.tc_done) begin
        n_tcd++;
        tcd_seen |= bus.tc_done;
        if (!bus.HRQ) tcd_rel++;
      end
      prev_ld = bus.ld_addr;
      if (!bus.HRQ) break;
    end
    done_cyc = cyc;
    chk("hrq_release", bus.HRQ, 0);
    bus.HLDA = 1'b0; bus.tc_in = 1'b0; bus.EOP_N = 1'b1; bus.addr_lo_wrap = 1'b0;
    tick();
  endtask

  task automatic chk_gaps(input string name, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) chk($sformatf("%s_gap%0d", name, i), gap_a[i], e[i]);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int saw;
    RESET = 1'b1;
    bus.DREQ = '0; bus.mask = '0; bus.sw_req = '0; bus.mode_block = '0;
    bus.cmd_disable = 1'b0; bus.cmd_rot_prio = 1'b0; bus.cmd_dreq_low = 1'b0;
    bus.cmd_dack_high = 1'b0; bus.cmd_compressed = 1'b0;
    bus.addr_lo_wrap = 1'b0; bus.tc_in = 1'b0; bus.EOP_N = 1'b1; bus.HLDA = 1'b0;

    //            dreq     mask     sw       lo   dis  hlda hrq  gv   gch   ld   xs   dack     pend
    tbl[0]  = '{4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0110};
    tbl[1]  = '{4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0110};
    tbl[2]  = '{4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 4'b0110};
    tbl[3]  = '{4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0010, 4'b0110};
    tbl[4]  = '{4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 4'b0010, 4'b0110};
    tbl[5]  = '{4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0110};
    tbl[6]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0100};
    tbl[7]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0100};
    tbl[8]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 4'b0100};
    tbl[9]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0100, 4'b0100};
    tbl[10] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 4'b0100, 4'b0100};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[13] = '{4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b1010};
    tbl[14] = '{4'b0000, 4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0100};
    tbl[15] = '{4'b1110, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0001};
    tbl[16] = '{4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[17] = '{4'b0000, 4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0111};

    // Reset state with active-low DACK, then switch polarity
    tick();
    tick();
    chk("reset_out", {bus.HRQ, bus.grant_vld, bus.grant_ch, bus.ld_addr, bus.xfer_stb,
                      bus.tc_done, bus.req_pending}, 0);
    chk("reset_dack", bus.DACK, 4'hF);
    bus.cmd_dack_high = 1'b1;
    RESET = 1'b0;
    tick();
    chk("idle_dack_high", {bus.HRQ, bus.DACK}, 0);

    // Cycle-accurate vector table
    for (int i = 0; i < 18; i++) begin
      bus.DREQ = tbl[i].dreq; bus.mask = tbl[i].mask; bus.sw_req = tbl[i].sw;
      bus.cmd_dreq_low = tbl[i].low; bus.cmd_disable = tbl[i].dis; bus.HLDA = tbl[i].hlda;
      tick();
      chk($sformatf("vec[%0d]", i),
          {bus.HRQ, bus.grant_vld, bus.grant_ch, bus.ld_addr, bus.xfer_stb, bus.DACK, bus.req_pending},
          {tbl[i].hrq, tbl[i].gv, tbl[i].gch, tbl[i].ld, tbl[i].xs, tbl[i].dack, tbl[i].pend});
    end
    bus.DREQ = '0; bus.mask = '0; bus.sw_req = '0; bus.cmd_dreq_low = 1'b0;
    bus.cmd_disable = 1'b0; bus.HLDA = 1'b0;
    do_reset();

    // Rotating priority: ch2, then all requesting -> ch3, ch0; fixed -> ch0
    bus.cmd_rot_prio = 1'b1;
    bus.DREQ = 4'b0100;
    run_xfer(0, 0, 0, 0, 1'b0, 1'b0);
    chk("rot_first_ch", g_ch, 2);
    chk("single_nstb", n_stb, 1);
    chk("single_no_tcd", n_tcd, 0);
    bus.DREQ = 4'b1111;
    run_xfer(0, 0, 0, 0, 1'b0, 1'b0);
    chk("rot_second_ch", g_ch, 3);
    run_xfer(0, 0, 0, 0, 1'b0, 1'b0);
    chk("rot_third_ch", g_ch, 0);
    bus.cmd_rot_prio = 1'b0;
    run_xfer(0, 0, 0, 0, 1'b0, 1'b0);
    chk("fixed_ignores_ptr", g_ch, 0);

    // Block mode ch0, tc on 4th transfer, request withdrawn and disable set after grant
    bus.DREQ = 4'b0001; bus.mode_block = 4'b0001;
    run_xfer(4, 0, 0, 0, 1'b0, 1'b1);
    chk("blk_ch", g_ch, 0);
    chk("blk_nstb", n_stb, 4);
    chk_gaps("blk", 3, 3, 3, 3);
    chk("blk_tcd", tcd_seen, 4'b0001);
    chk("blk_ntcd", n_tcd, 1);
    chk("blk_tcd_at_release", tcd_rel, 1);
    chk("blk_done_cyc", done_cyc, 13);

    // Disable now holds off the next request until cleared
    bus.DREQ = 4'b0001; bus.mask = '0;
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.HRQ) saw++;
    end
    chk("disable_no_hrq", saw, 0);
    chk("disable_no_pend", bus.req_pending, 0);
    bus.cmd_disable = 1'b0;
    tick();
    chk("enable_pend", bus.req_pending, 4'b0001);
    chk("enable_hrq", bus.HRQ, 1);

    // EOP low in S2 of the second block transfer
    run_xfer(0, 2, 0, 0, 1'b0, 1'b0);
    chk("eop_nstb", n_stb, 2);
    chk("eop_tcd", tcd_seen, 4'b0001);
    chk("eop_ntcd", n_tcd, 1);
    chk("eop_done_cyc", done_cyc, 7);

    // HLDA dropped in S2 of the first transfer
    run_xfer(0, 0, 1, 0, 1'b0, 1'b0);
    chk("drop_nstb", n_stb, 0);
    chk("drop_ntcd", n_tcd, 0);
    chk("drop_done_cyc", done_cyc, 3);

    // tc and EOP together in S4 of a single-mode transfer on ch1
    bus.DREQ = 4'b0010; bus.mode_block = 4'b0000;
    run_xfer(1, 0, 0, 0, 1'b1, 1'b0);
    chk("both_ch", g_ch, 1);
    chk("both_ntcd", n_tcd, 1);
    chk("both_tcd", tcd_seen, 4'b0010);
    chk("both_done_cyc", done_cyc, 4);

    // Compressed timing request, wrap on 3rd transfer, tc on 4th
    bus.DREQ = 4'b0001; bus.mode_block = 4'b0001; bus.cmd_compressed = 1'b1;
    run_xfer(4, 0, 0, 3, 1'b0, 1'b0);
    chk("cmp_nstb", n_stb, 4);
    chk("cmp_tcd", tcd_seen, 4'b0001);
`ifdef DMA_COMPRESSED_TIMING_EN
    chk_gaps("cmp", 3, 2, 2, 3);
    chk("cmp_done_cyc", done_cyc, 11);
`else
    chk_gaps("cmp", 3, 3, 3, 3);
    chk("cmp_done_cyc", done_cyc, 13);
`endif
    bus.cmd_compressed = 1'b0;

    // RESET while in S4
    for (int i = 0; i < 20 && !bus.HRQ; i++) tick();
    chk("rst_hrq", bus.HRQ, 1);
    bus.HLDA = 1'b1;
    for (int i = 0; i < 10 && !bus.xfer_stb; i++) tick();
    chk("rst_reach_s4", bus.xfer_stb, 1);
    RESET = 1'b1;
    tick();
    chk("rst_s4_out", {bus.HRQ, bus.grant_vld, bus.ld_addr, bus.xfer_stb, bus.DACK,
                       bus.tc_done, bus.req_pending}, 0);
    RESET = 1'b0; bus.HLDA = 1'b0; bus.DREQ = '0;
    tick();
    chk("rst_idle", {bus.HRQ, bus.grant_vld}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
